// File: rtl/eth_rx_hdr_pkg.sv
// rtl/eth_rx_hdr_pkg.sv - shared types and helpers for the 32-bit Ethernet header parser
package eth_rx_hdr_pkg;

  localparam int ETH_HDR_BYTES = 14;
  localparam int HDR_LAST_BEAT = ETH_HDR_BYTES / 4;

  typedef enum logic [1:0] {
    HDR     = 2'd0,
    PAYLOAD = 2'd1,
    FLUSH   = 2'd2
  } state_t;

  function automatic logic [2:0] keep_bytes(input logic [3:0] keep);
    case (keep)
      4'hF:    keep_bytes = 3'd4;
      4'h7:    keep_bytes = 3'd3;
      4'h3:    keep_bytes = 3'd2;
      4'h1:    keep_bytes = 3'd1;
      default: keep_bytes = 3'd0;
    endcase
  endfunction

  // Lane 0 is the earliest wire byte; header fields are big-endian.
  function automatic logic [31:0] bswap32(input logic [31:0] d);
    bswap32 = {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

endpackage

// File: rtl/eth_axis_rx_hdr_32.sv
// rtl/eth_axis_rx_hdr_32.sv - strips the Ethernet header and realigns payload by 2 bytes
// Optional statistics counters are enabled by defining ETH_RX_HDR_STATS_EN.
module eth_axis_rx_hdr_32
  import eth_rx_hdr_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  input  logic                  s_axis_tlast,
  input  logic                  s_axis_tuser,
  output logic                  m_eth_hdr_valid,
  output logic [47:0]           m_eth_dest_mac,
  output logic [47:0]           m_eth_src_mac,
  output logic [15:0]           m_eth_type,
  output logic [DATA_WIDTH-1:0] m_eth_payload_axis_tdata,
  output logic [KEEP_WIDTH-1:0] m_eth_payload_axis_tkeep,
  output logic                  m_eth_payload_axis_tvalid,
  output logic                  m_eth_payload_axis_tlast,
  output logic                  m_eth_payload_axis_tuser,
  output logic                  error_header_early_termination
`ifdef ETH_RX_HDR_STATS_EN
  ,
  output logic [31:0]           stat_frame_count,
  output logic [31:0]           stat_runt_count
`endif
);

  if (DATA_WIDTH != 32 || KEEP_WIDTH != 4) begin : g_width_check
    $error("eth_axis_rx_hdr_32 supports only DATA_WIDTH=32, KEEP_WIDTH=4");
  end

  state_t        state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [15:0]   hold_q, hold_d;
  logic [95:0]   shadow_q, shadow_d;
  logic [3:0]    flush_keep_q, flush_keep_d;
  logic          flush_user_q, flush_user_d;
  logic [47:0]   dest_q, dest_d, src_q, src_d;
  logic [15:0]   type_q, type_d;
  logic          hdr_valid_q, hdr_valid_d, err_q, err_d;
  logic [31:0]   p_data_q, p_data_d;
  logic [3:0]    p_keep_q, p_keep_d;
  logic          p_valid_q, p_valid_d, p_last_q, p_last_d, p_user_q, p_user_d;
  logic [2:0]    in_bytes;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= HDR;         cnt_q <= '0;        hold_q <= '0;
      shadow_q <= '0;         flush_keep_q <= '0; flush_user_q <= 1'b0;
      dest_q <= '0;           src_q <= '0;        type_q <= '0;
      hdr_valid_q <= 1'b0;    err_q <= 1'b0;
      p_data_q <= '0;         p_keep_q <= '0;     p_valid_q <= 1'b0;
      p_last_q <= 1'b0;       p_user_q <= 1'b0;
    end else begin
      state_q <= state_d;     cnt_q <= cnt_d;     hold_q <= hold_d;
      shadow_q <= shadow_d;   flush_keep_q <= flush_keep_d; flush_user_q <= flush_user_d;
      dest_q <= dest_d;       src_q <= src_d;     type_q <= type_d;
      hdr_valid_q <= hdr_valid_d; err_q <= err_d;
      p_data_q <= p_data_d;   p_keep_q <= p_keep_d; p_valid_q <= p_valid_d;
      p_last_q <= p_last_d;   p_user_q <= p_user_d;
    end
  end

  always_comb begin
    state_d = state_q;   cnt_d = cnt_q;       hold_d = hold_q;
    shadow_d = shadow_q; flush_keep_d = flush_keep_q; flush_user_d = flush_user_q;
    dest_d = dest_q;     src_d = src_q;       type_d = type_q;
    hdr_valid_d = 1'b0;  err_d = 1'b0;
    p_data_d = p_data_q; p_keep_d = p_keep_q; p_valid_d = 1'b0;
    p_last_d = 1'b0;     p_user_d = 1'b0;
    in_bytes = keep_bytes(s_axis_tkeep);

    case (state_q)
      PAYLOAD: begin
        if (s_axis_tvalid) begin
          p_valid_d = 1'b1;
          p_data_d  = {s_axis_tdata[15:0], hold_q};
          p_keep_d  = 4'hF;
          hold_d    = s_axis_tdata[31:16];
          if (s_axis_tlast) begin
            if (in_bytes <= 3'd2) begin
              p_keep_d = (in_bytes == 3'd1) ? 4'h7 : 4'hF;
              p_last_d = 1'b1;
              p_user_d = s_axis_tuser;
              state_d  = HDR;
            end else begin
              flush_keep_d = (in_bytes == 3'd3) ? 4'h1 : 4'h3;
              flush_user_d = s_axis_tuser;
              state_d      = FLUSH;
            end
          end
        end
      end
      FLUSH: begin
        p_valid_d = 1'b1;
        p_data_d  = {16'h0000, hold_q};
        p_keep_d  = flush_keep_q;
        p_last_d  = 1'b1;
        p_user_d  = flush_user_q;
        state_d   = HDR;
      end
      default: ;
    endcase

    // The FLUSH cycle doubles as header beat 0 of a back-to-back frame.
    if (s_axis_tvalid && state_q != PAYLOAD) begin
      case (cnt_q)
        2'd0:    shadow_d[95:64] = bswap32(s_axis_tdata);
        2'd1:    shadow_d[63:32] = bswap32(s_axis_tdata);
        2'd2:    shadow_d[31:0]  = bswap32(s_axis_tdata);
        default: ;
      endcase
      if (s_axis_tlast && (cnt_q != 2'(HDR_LAST_BEAT) || in_bytes <= 3'd2)) begin
        err_d   = 1'b1;
        cnt_d   = '0;
        state_d = HDR;
      end else if (cnt_q == 2'(HDR_LAST_BEAT)) begin
        hdr_valid_d = 1'b1;
        dest_d      = shadow_q[95:48];
        src_d       = shadow_q[47:0];
        type_d      = {s_axis_tdata[7:0], s_axis_tdata[15:8]};
        hold_d      = s_axis_tdata[31:16];
        cnt_d       = '0;
        if (s_axis_tlast) begin
          flush_keep_d = (in_bytes == 3'd3) ? 4'h1 : 4'h3;
          flush_user_d = s_axis_tuser;
          state_d      = FLUSH;
        end else begin
          state_d = PAYLOAD;
        end
      end else begin
        cnt_d = cnt_q + 2'd1;
      end
    end
  end

  assign m_eth_hdr_valid                = hdr_valid_q;
  assign m_eth_dest_mac                 = dest_q;
  assign m_eth_src_mac                  = src_q;
  assign m_eth_type                     = type_q;
  assign m_eth_payload_axis_tdata       = p_data_q;
  assign m_eth_payload_axis_tkeep       = p_keep_q;
  assign m_eth_payload_axis_tvalid      = p_valid_q;
  assign m_eth_payload_axis_tlast       = p_last_q;
  assign m_eth_payload_axis_tuser       = p_user_q;
  assign error_header_early_termination = err_q;

`ifdef ETH_RX_HDR_STATS_EN
  logic [31:0] frame_cnt_q, runt_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_q <= '0;
      runt_cnt_q  <= '0;
    end else begin
      if (hdr_valid_q && frame_cnt_q != 32'hFFFF_FFFF) frame_cnt_q <= frame_cnt_q + 32'd1;
      if (err_q && runt_cnt_q != 32'hFFFF_FFFF)        runt_cnt_q  <= runt_cnt_q + 32'd1;
    end
  end

  assign stat_frame_count = frame_cnt_q;
  assign stat_runt_count  = runt_cnt_q;
`endif

endmodule

// File: tb/tb_eth_axis_rx_hdr_32.sv
// tb/tb_eth_axis_rx_hdr_32.sv - directed table-driven bench for eth_axis_rx_hdr_32
module tb_eth_axis_rx_hdr_32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] s_tdata = '0;
  logic [3:0]  s_tkeep = '0;
  logic        s_tvalid = 1'b0, s_tlast = 1'b0, s_tuser = 1'b0;
  logic        hdr_valid;
  logic [47:0] dest, src;
  logic [15:0] etype;
  logic [31:0] p_data;
  logic [3:0]  p_keep;
  logic        p_valid, p_last, p_user, err;
`ifdef ETH_RX_HDR_STATS_EN
  logic [31:0] stat_frames, stat_runts;
`endif

  always #5 clk = ~clk;

  eth_axis_rx_hdr_32 dut (
    .clk                            (clk),
    .rst_n                          (rst_n),
    .s_axis_tdata                   (s_tdata),
    .s_axis_tkeep                   (s_tkeep),
    .s_axis_tvalid                  (s_tvalid),
    .s_axis_tlast                   (s_tlast),
    .s_axis_tuser                   (s_tuser),
    .m_eth_hdr_valid                (hdr_valid),
    .m_eth_dest_mac                 (dest),
    .m_eth_src_mac                  (src),
    .m_eth_type                     (etype),
    .m_eth_payload_axis_tdata       (p_data),
    .m_eth_payload_axis_tkeep       (p_keep),
    .m_eth_payload_axis_tvalid      (p_valid),
    .m_eth_payload_axis_tlast       (p_last),
    .m_eth_payload_axis_tuser       (p_user),
    .error_header_early_termination (err)
`ifdef ETH_RX_HDR_STATS_EN
    ,
    .stat_frame_count               (stat_frames),
    .stat_runt_count                (stat_runts)
`endif
  );

  typedef struct {
    int         len;
    bit         user;
    bit         gap;
    logic [7:0] base;
    int         exp_hdr;
    int         exp_err;
    int         exp_beats;
    logic [3:0] exp_keep;
    bit         exp_user;
  } vec_t;

  int errors = 0;
  int checks = 0;

  int n_hdr = 0, n_err = 0, n_beats = 0, n_order = 0, n_badkeep = 0;
  bit hdr_seen = 1'b0;
  logic [7:0] pq[$];
  logic [3:0] lk_q[$];
  logic       lu_q[$];
  logic [47:0] cap_dest = '0, cap_src = '0;
  logic [15:0] cap_type = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      hdr_seen = 1'b0;
    end else begin
      if (hdr_valid) begin
        n_hdr++;
        hdr_seen = 1'b1;
        cap_dest = dest; cap_src = src; cap_type = etype;
      end
      if (err) n_err++;
      if (p_valid) begin
        n_beats++;
        if (!hdr_seen) n_order++;
        if (!(p_keep inside {4'h1, 4'h3, 4'h7, 4'hF})) n_badkeep++;
        for (int k = 0; k < 4; k++) if (p_keep[k]) pq.push_back(p_data[8*k +: 8]);
        if (p_last) begin
          lk_q.push_back(p_keep);
          lu_q.push_back(p_user);
          hdr_seen = 1'b0;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic send_frame(input int len, input bit user, input logic [7:0] base,
                            input int max_beats, input bit gap);
    int nb;
    nb = (len + 3) / 4;
    for (int bt = 0; bt < nb && (max_beats < 0 || bt < max_beats); bt++) begin
      s_tdata = '0;
      s_tkeep = '0;
      for (int k = 0; k < 4; k++) begin
        if (bt * 4 + k < len) begin
          s_tdata[8*k +: 8] = 8'(int'(base) + bt * 4 + k);
          s_tkeep[k] = 1'b1;
        end
      end
      s_tvalid = 1'b1;
      s_tlast  = (bt == nb - 1);
      s_tuser  = (bt == nb - 1) ? user : 1'b0;
      @(posedge clk); #1;
      if (gap && bt == 1) begin
        s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
        @(posedge clk); #1;
      end
    end
    s_tvalid = 1'b0; s_tlast = 1'b0; s_tuser = 1'b0;
  endtask

  int b_hdr, b_err, b_beats, b_order, b_bad, b_q, b_lk;

  task automatic snap();
    b_hdr = n_hdr; b_err = n_err; b_beats = n_beats; b_order = n_order;
    b_bad = n_badkeep; b_q = pq.size(); b_lk = lk_q.size();
  endtask

  function automatic logic [47:0] mac_of(input logic [7:0] base, input int off);
    logic [47:0] m;
    m = '0;
    for (int k = 0; k < 6; k++) m = {m[39:0], 8'(int'(base) + off + k)};
    return m;
  endfunction

  task automatic verify(input string nm, input vec_t v);
    int nbytes, mism;
    nbytes = (v.exp_hdr > 0) ? v.len - 14 : 0;
    chk({nm, ".hdr_strobes"}, 64'(n_hdr - b_hdr), 64'(v.exp_hdr));
    chk({nm, ".runt_pulses"}, 64'(n_err - b_err), 64'(v.exp_err));
    chk({nm, ".beats"}, 64'(n_beats - b_beats), 64'(v.exp_beats));
    chk({nm, ".hdr_order"}, 64'(n_order - b_order), 64'd0);
    chk({nm, ".keep_shape"}, 64'(n_badkeep - b_bad), 64'd0);
    chk({nm, ".bytes"}, 64'(pq.size() - b_q), 64'(nbytes));
    mism = 0;
    for (int i = 0; i < pq.size() - b_q; i++)
      if (pq[b_q + i] !== 8'(int'(v.base) + 14 + i)) mism++;
    chk({nm, ".byte_data"}, 64'(mism), 64'd0);
    chk({nm, ".tlasts"}, 64'(lk_q.size() - b_lk), (v.exp_beats > 0) ? 64'd1 : 64'd0);
    if (v.exp_beats > 0 && lk_q.size() > b_lk) begin
      chk({nm, ".last_keep"}, 64'(lk_q[b_lk]), 64'(v.exp_keep));
      chk({nm, ".last_user"}, 64'(lu_q[b_lk]), 64'(v.exp_user));
    end
    if (v.exp_hdr > 0) begin
      chk({nm, ".dest"}, 64'(cap_dest), 64'(mac_of(v.base, 0)));
      chk({nm, ".src"},  64'(cap_src),  64'(mac_of(v.base, 6)));
      chk({nm, ".type"}, 64'(cap_type), 64'({8'(int'(v.base) + 12), 8'(int'(v.base) + 13)}));
    end
  endtask

  vec_t vecs[7];
  vec_t v64;

  initial begin
    //       len user gap base   hdr err beats keep  user
    vecs[0] = '{61, 1'b1, 1'b1, 8'h10, 1, 0, 12, 4'h7, 1'b1};
    vecs[1] = '{63, 1'b0, 1'b0, 8'h20, 1, 0, 13, 4'h1, 1'b0};
    vecs[2] = '{14, 1'b0, 1'b0, 8'h30, 0, 1,  0, 4'h0, 1'b0};
    vecs[3] = '{ 8, 1'b0, 1'b0, 8'h38, 0, 1,  0, 4'h0, 1'b0};
    vecs[4] = '{15, 1'b0, 1'b0, 8'h00, 1, 0,  1, 4'h1, 1'b0};
    vecs[5] = '{16, 1'b1, 1'b0, 8'h50, 1, 0,  1, 4'h3, 1'b1};
    vecs[6] = '{18, 1'b0, 1'b1, 8'h60, 1, 0,  1, 4'hF, 1'b0};
    v64     = '{64, 1'b0, 1'b0, 8'h00, 1, 0, 13, 4'h3, 1'b0};

    repeat (3) @(posedge clk);
    #1;
    chk("reset.outputs", 64'(|{hdr_valid, dest, src, etype, p_data, p_keep, p_valid, p_last, p_user, err}), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    snap();
    send_frame(64, 1'b0, 8'h00, -1, 1'b0);
    repeat (4) @(posedge clk); #1;
    verify("f64", v64);
    chk("f64.dest_const", 64'(cap_dest), 64'h0000_0001_0203_0405);
    chk("f64.src_const",  64'(cap_src),  64'h0000_0607_0809_0A0B);
    chk("f64.type_const", 64'(cap_type), 64'h0C0D);

    for (int i = 0; i < 7; i++) begin
      snap();
      send_frame(vecs[i].len, vecs[i].user, vecs[i].base, -1, vecs[i].gap);
      repeat (4) @(posedge clk); #1;
      verify($sformatf("vec%0d_len%0d", i, vecs[i].len), vecs[i]);
    end
`ifdef ETH_RX_HDR_STATS_EN
    chk("stats.runts", 64'(stat_runts), 64'd2);
    chk("stats.frames", 64'(stat_frames), 64'd6);
`endif

    snap();
    send_frame(63, 1'b1, 8'h70, -1, 1'b0);
    send_frame(64, 1'b0, 8'hA0, -1, 1'b0);
    repeat (4) @(posedge clk); #1;
    begin
      int mism;
      chk("b2b.hdr_strobes", 64'(n_hdr - b_hdr), 64'd2);
      chk("b2b.runt_pulses", 64'(n_err - b_err), 64'd0);
      chk("b2b.bytes", 64'(pq.size() - b_q), 64'd99);
      mism = 0;
      for (int i = 0; i < pq.size() - b_q && i < 99; i++)
        if (pq[b_q + i] !== ((i < 49) ? 8'(8'h70 + 14 + i) : 8'(8'hA0 + 14 + i - 49))) mism++;
      chk("b2b.byte_data", 64'(mism), 64'd0);
      chk("b2b.tlasts", 64'(lk_q.size() - b_lk), 64'd2);
      if (lk_q.size() - b_lk == 2) begin
        chk("b2b.flush_keep", 64'(lk_q[b_lk]), 64'h1);
        chk("b2b.flush_user", 64'(lu_q[b_lk]), 64'd1);
        chk("b2b.second_keep", 64'(lk_q[b_lk + 1]), 64'h3);
      end
      chk("b2b.dest2", 64'(cap_dest), 64'(mac_of(8'hA0, 0)));
      chk("b2b.type2", 64'(cap_type), 64'h0000_0000_0000_ACAD);
    end

    send_frame(64, 1'b0, 8'h40, 7, 1'b0);
    chk("rst_mid.payload_active", 64'(p_valid), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid.outputs_async", 64'(|{hdr_valid, dest, src, etype, p_data, p_keep, p_valid, p_last, p_user, err}), 64'd0);
`ifdef ETH_RX_HDR_STATS_EN
    chk("rst_mid.stats", 64'(|{stat_frames, stat_runts}), 64'd0);
`endif
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    snap();
    v64.base = 8'h80;
    send_frame(64, 1'b0, 8'h80, -1, 1'b0);
    repeat (4) @(posedge clk); #1;
    verify("after_rst", v64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/eth_axis_rx_hdr_32.md
Name: eth_axis_rx_hdr_32

Overview:
- Sits directly downstream of the 32-bit XGMII frame receiver; consumes its AXI-stream frame output (no tready; the MAC side never stalls).
- Strips the 14-byte Ethernet header and presents dest MAC, src MAC and ethertype on a one-cycle header strobe.
- Realigns the payload by 2 bytes onto its own stream, lane 0 first.
- Flags frames too short to carry header plus at least one payload byte.

Parameters:
- DATA_WIDTH, 32, stream width; any other value is an elaboration error.
- KEEP_WIDTH, DATA_WIDTH/8, byte-enable width; must equal 4.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_axis_tdata  in  32  input frame data, byte 0 in [7:0]
- s_axis_tkeep  in  4  contiguous from lane 0; 4'hF on all non-last beats
- s_axis_tvalid  in  1  beat valid; no ready, every valid beat is consumed
- s_axis_tlast  in  1  last beat of frame
- s_axis_tuser  in  1  bad-frame flag, meaningful on last beat only
- m_eth_hdr_valid  out  1  one-cycle header strobe
- m_eth_dest_mac  out  48  frame bytes 0..5, byte 0 in [47:40]
- m_eth_src_mac  out  48  frame bytes 6..11, byte 6 in [47:40]
- m_eth_type  out  16  byte 12 in [15:8], byte 13 in [7:0]
- m_eth_payload_axis_tdata  out  32  payload data, payload byte 0 in [7:0]
- m_eth_payload_axis_tkeep  out  4  payload byte enables
- m_eth_payload_axis_tvalid  out  1  payload beat valid
- m_eth_payload_axis_tlast  out  1  last payload beat
- m_eth_payload_axis_tuser  out  1  copy of input tuser, on the last beat only
- error_header_early_termination  out  1  one-cycle pulse: frame of 14 bytes or fewer

Behaviour:
- Reset (async assert, sync release): every output, valid, strobe and pulse is 0; header fields are 0; state HDR; beat counter 0.
- Reset mid-frame: the remaining beats of that frame are parsed as a new frame. Integration holds rst_n across a frame boundary.
- States:
  - HDR: counts input beats 0..3. Beats 0-2 and beat 3 bytes 0-1 load the header registers. Beat 3 upper half (frame bytes 14,15) goes to the hold register.
  - PAYLOAD: each input beat emits {in[15:0], hold[15:0]} and reloads hold with in[31:16].
  - FLUSH: emits the leftover hold bytes.
- HDR exits:
  - tlast on beat 0, 1 or 2, or on beat 3 with tkeep 4'h3: runt. Pulse error_header_early_termination one cycle later; no header strobe, no payload; stay in HDR, counter 0.
  - Beat 3 non-last: strobe m_eth_hdr_valid one cycle later; go to PAYLOAD.
  - Beat 3 last with tkeep 4'h7 or 4'hF: strobe the header; go to FLUSH with n = 1 or 2 hold bytes.
- PAYLOAD last beat with n input bytes:
  - n <= 2: emit that beat with tlast, tkeep = 2+n bytes; go to HDR.
  - n >= 3: emit a full non-last beat; go to FLUSH holding n-2 bytes.
- FLUSH: emit one beat with tlast, tkeep 4'h1 or 4'h3, tuser = captured input tuser; go to HDR. Input beat 0 of the next frame in the same cycle is taken as header beat 0 (back-to-back supported).
- Latency: each payload beat and the header strobe are registered, one clk after the input beat that completes them.
- The header strobe precedes or coincides with the first payload beat, never follows it.
- Header fields hold their value until the next header capture.
- tvalid gaps within a frame are allowed; state holds across them.

Optional Feature:
- Macro ETH_RX_HDR_STATS_EN.
- Defined:
  - Adds outputs stat_frame_count [31:0] and stat_runt_count [31:0].
  - stat_frame_count increments on each header strobe; stat_runt_count increments on each early-termination pulse.
  - Both counters saturate at 32'hFFFFFFFF and reset to 0.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package eth_rx_hdr_pkg: ETH_HDR_BYTES = 14, the state encoding (HDR, PAYLOAD, FLUSH), and the keep-to-byte-count function.
- No sub-module; the realign datapath is small enough to live inline.

Test Plan:
- 64-byte frame, bytes 0x00..0x3F, tuser 0 -> header strobe with dest 0x000102030405, src 0x060708090A0B, type 0x0C0D. Payload 50 bytes 0x0E..0x3F: 12 full beats plus a last beat with tkeep 4'h3, tuser 0.
- 61-byte frame (last input keep 4'h1), tuser 1 on last -> 47 payload bytes: 11 full beats plus a last beat with keep 4'h7, tuser 1, no FLUSH cycle.
- 63-byte frame (last keep 4'h7) -> PAYLOAD emits a full non-last beat, then FLUSH emits a tlast beat with keep 4'h1. The next frame's beat 0 arrives in the FLUSH cycle and must parse correctly.
- 14-byte frame (beat 3 keep 4'h3) and 8-byte frame -> one early-termination pulse each; no header strobe, no payload. With ETH_RX_HDR_STATS_EN, stat_runt_count = 2.
- 15-byte frame -> header strobe plus one payload beat with data byte 0x0E, keep 4'h1, tlast.
- Deassert rst_n mid-payload of a 64-byte frame -> all outputs 0 immediately (asynchronously). A subsequent 64-byte frame starting after release parses correctly.
